instr_fetch: RTL

- Front stage of the single-cycle core. Owns the PC, requests instruction words from instruction memory and presents one instruction plus its PC to the decoder.
- Computes the next PC once the instruction is consumed, from the decoder's branch/jump/immediate and the branch-condition result.
- Supports instruction memories with variable ready latency via a req/ready handshake.

---
 rtl/instr_fetch_pkg.sv | 14 +
 rtl/instr_fetch_next_pc_sel.sv | 22 ++
 rtl/instr_fetch.sv | 104 ++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: state codes, NOP word and PC increment.
// Consumed by instr_fetch and next_pc_sel.
package instr_fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_ST = 2'd0,
      VALID_ST = 2'd1,
      HALT_ST  = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
   localparam logic [31:0] PC_INCR       = 32'd4;

endpackage

// File: rtl/instr_fetch_next_pc_sel.sv
// Next-PC selection for the fetch stage: sequential vs. redirect target,
// plus word-alignment check of the result.
module next_pc_sel
   import instr_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [31:0] immediate,
   output logic [31:0] next_pc,
   output logic        misaligned_tgt
);

   logic redirect;

   // A jump wins even when branch is set but not taken.
   assign redirect       = (branch & branch_taken) | jump;
   assign next_pc        = redirect ? (pc + immediate) : (pc + PC_INCR);
   assign misaligned_tgt = (next_pc[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, handshakes with instruction memory and holds one
// instruction for the decoder. Define FETCH_PERF_EN to add retired/stall counters.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   output logic        instr_valid,
   input  logic        instr_accept,
   input  logic        branch,
   input  logic        branch_taken,
   input  logic        jump,
   input  logic [31:0] immediate,
   output logic        misaligned
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt
`endif
);

   state_t      state, state_nxt;
   logic        req_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        misaligned_q;
   logic [31:0] next_pc;
   logic        misaligned_tgt;
   logic        fire;
   logic        retire;

   next_pc_sel u_next_pc_sel (
      .pc             (pc_q),
      .branch         (branch),
      .branch_taken   (branch_taken),
      .jump           (jump),
      .immediate      (immediate),
      .next_pc        (next_pc),
      .misaligned_tgt (misaligned_tgt)
   );

   assign fire   = (state == FETCH_ST) & req_q & imem_ready;
   assign retire = (state == VALID_ST) & instr_accept;

   always_comb begin
      state_nxt = state;
      case (state)
         FETCH_ST: if (fire)   state_nxt = VALID_ST;
         VALID_ST: if (retire) state_nxt = misaligned_tgt ? HALT_ST : FETCH_ST;
         HALT_ST:              state_nxt = HALT_ST;
         default:              state_nxt = FETCH_ST;
      endcase
   end

   // req is registered so it stays low through reset and rises one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH_ST;
         req_q        <= 1'b0;
         pc_q         <= RESET_PC;
         instr_q      <= NOP_INSTR;
         misaligned_q <= 1'b0;
      end else begin
         state <= state_nxt;
         req_q <= (state_nxt == FETCH_ST);
         if (fire) instr_q <= imem_rdata;
         if (retire) begin
            instr_q <= NOP_INSTR;
            if (misaligned_tgt) misaligned_q <= 1'b1;
            else                pc_q         <= next_pc;
         end
      end
   end

   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state == VALID_ST);
   assign misaligned  = misaligned_q;

`ifdef FETCH_PERF_EN
   // Neither condition can hold in HALT, so both counters freeze there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 32'd0;
         stall_cnt   <= 32'd0;
      end else begin
         if (retire) retired_cnt <= retired_cnt + 32'd1;
         if ((state == FETCH_ST) && !imem_ready) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule
